// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: datapath plus FSM on one shared memory port.
// Define MIPS_PERF_CNT_EN to add the cyc_cnt/ret_cnt performance counters.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        retire,
  output logic        halted,
  output logic [31:0] pc_out
`ifdef MIPS_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  localparam int RW = $clog2(NREGS);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I,
    ALUWB, MEMADR, MEMRD, MEMWB,
    MEMWR, BRANCH, JUMP, HALT
  } state_t;

  state_t state, state_n;

  logic [31:0] pc, ipc, ir;
  logic [31:0] a, b, alu_q, mdr;
  logic        run;
  logic [31:0] rf [NREGS];

  logic [5:0]    op, fn;
  logic [4:0]    shamt;
  logic [RW-1:0] rs, rt, rd, wa;
  logic [31:0]   imm, rs_v, rt_v, alu_r;
  logic          is_r, is_alu_r, is_jr, is_addi;
  logic          is_lw, is_sw, is_beq, is_bne, is_j;
  logic          xfer, taken;

  assign op    = ir[31:26];
  assign fn    = ir[5:0];
  assign shamt = ir[10:6];
  assign rs    = ir[21 +: RW];
  assign rt    = ir[16 +: RW];
  assign rd    = ir[11 +: RW];
  assign imm   = {{16{ir[15]}}, ir[15:0]};

  assign is_r     = (op == 6'h00);
  assign is_alu_r = is_r && (fn inside
    {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02});
  assign is_jr    = is_r && (fn == 6'h08);
  assign is_addi  = (op == 6'h08);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2b);
  assign is_beq   = (op == 6'h04);
  assign is_bne   = (op == 6'h05);
  assign is_j     = (op == 6'h02);

  assign rs_v  = (rs == '0) ? '0 : rf[rs];
  assign rt_v  = (rt == '0) ? '0 : rf[rt];
  assign wa    = is_r ? rd : rt;
  assign xfer  = mem_req && mem_ready;
  assign taken = (is_beq && (a == b)) || (is_bne && (a != b));

  always_comb begin
    case (fn)
      6'h20:   alu_r = a + b;
      6'h22:   alu_r = a - b;
      6'h24:   alu_r = a & b;
      6'h25:   alu_r = a | b;
      6'h2a:   alu_r = {31'b0, $signed(a) < $signed(b)};
      6'h00:   alu_r = b << shamt;
      6'h02:   alu_r = b >> shamt;
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {alu_q[31:2], 2'b00};
    mem_wdata = b;
    retire    = 1'b0;
    halted    = 1'b0;
    pc_out    = ipc;
    case (state)
      FETCH: begin
        mem_req  = run;
        mem_addr = {pc[31:2], 2'b00};
        pc_out   = pc;
        if (xfer) state_n = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          is_alu_r:        state_n = EXEC_R;
          is_addi:         state_n = EXEC_I;
          is_lw | is_sw:   state_n = MEMADR;
          is_beq | is_bne: state_n = BRANCH;
          is_j | is_jr:    state_n = JUMP;
          default:         state_n = HALT;
        endcase
      end
      EXEC_R, EXEC_I: state_n = ALUWB;
      MEMADR: state_n = is_lw ? MEMRD : MEMWR;
      MEMRD: begin
        mem_req = run;
        if (xfer) state_n = MEMWB;
      end
      MEMWR: begin
        mem_req = run;
        mem_we  = 1'b1;
        retire  = xfer;
        if (xfer) state_n = FETCH;
      end
      ALUWB, MEMWB, BRANCH, JUMP: begin
        retire  = 1'b1;
        state_n = FETCH;
      end
      HALT:    halted  = 1'b1;
      default: state_n = FETCH;
    endcase
  end

  // ipc keeps the address of the instruction in flight; pc runs 4 ahead
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      ipc   <= RESET_PC;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      alu_q <= '0;
      mdr   <= '0;
      run   <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        FETCH: if (xfer) begin
          ir  <= mem_rdata;
          ipc <= pc;
          pc  <= pc + 32'd4;
        end
        DECODE: begin
          a <= rs_v;
          b <= rt_v;
        end
        EXEC_R: alu_q <= alu_r;
        EXEC_I, MEMADR: alu_q <= a + imm;
        ALUWB: if (wa != '0) rf[wa] <= alu_q;
        MEMRD: if (xfer) mdr <= mem_rdata;
        MEMWB: if (rt != '0) rf[rt] <= mdr;
        BRANCH: if (taken) pc <= pc + {imm[29:0], 2'b00};
        JUMP: begin
          if (is_jr) pc <= {a[31:2], 2'b00};
          else       pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        default: ;
      endcase
    end
  end

`ifdef MIPS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (!halted) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire)  ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core: directed programs run against a
// wait-state memory model; bus transfers and per-instruction cycles are checked.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        retire, halted;
  logic [31:0] pc_out;
`ifdef MIPS_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  always #5 clk = ~clk;

  mips_multicycle_core dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .retire    (retire),
    .halted    (halted),
    .pc_out    (pc_out)
`ifdef MIPS_PERF_CNT_EN
    ,
    .cyc_cnt   (cyc_cnt),
    .ret_cnt   (ret_cnt)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  int          cyc_q[$];
  logic [31:0] mem [256];
  int          tests = 0;
  int          failed = 0;
  int          waits = 0;
  int          rcnt;
  int          nret = 0;
  int          samp = 0;
  int          last = 0;
  bit          started = 0;
  bit          strict = 1;
  bit          stall_en = 0;
  logic [31:0] stall_addr = '0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic ins(input logic [31:0] addr, input logic [31:0] w,
                     input int cyc);
    mem[addr[9:2]] = w;
    exp_q.push_back(txn_t'{1'b0, addr, 32'h0});
    if (cyc != 0) begin
      cyc_q.push_back(cyc);
      nret++;
    end
  endtask

  task automatic refetch(input logic [31:0] addr, input int cyc);
    exp_q.push_back(txn_t'{1'b0, addr, 32'h0});
    if (cyc != 0) cyc_q.push_back(cyc);
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] d);
    exp_q.push_back(txn_t'{1'b1, addr, d});
  endtask

  task automatic ld(input logic [31:0] addr);
    exp_q.push_back(txn_t'{1'b0, addr, 32'h0});
  endtask

  // memory: grants after `waits` stalled cycles, stores on grant
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    rcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_ready || !mem_req) rcnt = 0;
      mem_ready = 1'b0;
      if (mem_req && !(stall_en && mem_addr == stall_addr)) begin
        if (rcnt >= waits) begin
          mem_ready = 1'b1;
          if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
          else        mem_rdata = mem[mem_addr[9:2]];
        end else begin
          rcnt++;
        end
      end
    end
  end

  // monitor: pops expectations whenever a transfer or retire is presented
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      #1;
      samp++;
      if (mem_req && !started) begin
        started = 1;
        last = samp - 1;
      end
      if (mem_req && mem_ready) begin
        if (exp_q.size() == 0) begin
          if (strict) begin
            tests++;
            failed++;
            $display("FAIL unexpected_txn: got addr %h we %b, required none",
                     mem_addr, mem_we);
          end
        end else begin
          e = exp_q.pop_front();
          check("txn_we", 32'(mem_we), 32'(e.we));
          check("txn_addr", mem_addr, e.addr);
          if (e.we) check("store_data", mem_wdata, e.data);
        end
      end
      if (retire) begin
        if (cyc_q.size() != 0) begin
          check("retire_cycles", 32'(samp - last), 32'(cyc_q.pop_front()));
        end else if (strict) begin
          tests++;
          failed++;
          $display("FAIL unexpected_retire: got retire at pc %h, required none",
                   pc_out);
        end
        last = samp;
      end
    end
  end

  task automatic start_phase(input int w, input bit s);
    @(negedge clk);
    reset = 1'b1;
    stall_en = 0;
    waits = w;
    strict = s;
    exp_q.delete();
    cyc_q.delete();
    nret = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    started = 0;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_retire", 32'(retire), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_pc", pc_out, 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cyc_q.size() != 0) && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({nm, "_drain"}, 32'(exp_q.size() + cyc_q.size()), 32'h0);
  endtask

  task automatic check_halt(input string nm, input logic [31:0] pc_req);
    int bad;
`ifdef MIPS_PERF_CNT_EN
    logic [31:0] c0;
`endif
    bad = 0;
    repeat (3) @(negedge clk);
    #2;
`ifdef MIPS_PERF_CNT_EN
    c0 = cyc_cnt;
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      if (mem_req !== 1'b0 || retire !== 1'b0 || pc_out !== pc_req) bad++;
    end
    check({nm, "_halted"}, 32'(halted), 32'h1);
    check({nm, "_halt_pc"}, pc_out, pc_req);
    check({nm, "_halt_idle"}, 32'(bad), 32'h0);
`ifdef MIPS_PERF_CNT_EN
    check({nm, "_cyc_frozen"}, cyc_cnt, c0);
    check({nm, "_ret_cnt"}, ret_cnt, 32'(nret));
`endif
  endtask

  initial begin
    int n;
    reset = 1'b1;

    // reset in the middle of a stalled lw
    start_phase(0, 1);
    stall_en = 1;
    stall_addr = 32'h80;
    ins(32'h00, 32'h2001_0009, 4);
    ins(32'h04, 32'h2002_0007, 4);
    ins(32'h08, 32'h8C03_0080, 0);
    release_reset();
    drain("pre_rst", 200);
    n = 0;
    while (!(mem_req && mem_addr == 32'h80) && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    repeat (3) @(negedge clk);
    #2;
    check("stall_req", 32'(mem_req), 32'h1);
    check("stall_addr", mem_addr, 32'h80);
    check("stall_pc", pc_out, 32'h08);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2;
    check("rst_drop_req", 32'(mem_req), 32'h0);

    // registers must read back zero after that reset
    start_phase(0, 1);
    ins(32'h00, 32'hAC01_00A0, 4); st(32'hA0, 32'h0);
    ins(32'h04, 32'hAC02_00A4, 4); st(32'hA4, 32'h0);
    ins(32'h08, 32'hAC03_00A8, 4); st(32'hA8, 32'h0);
    ins(32'h0C, 32'hFC00_0000, 0);
    release_reset();
    drain("post_rst", 300);
    check_halt("post_rst", 32'h0C);

    // ALU, branches, jumps, load/store at zero wait
    start_phase(0, 1);
    ins(32'h000, 32'h2001_0005, 4);
    ins(32'h004, 32'h2002_FFFD, 4);
    ins(32'h008, 32'h0022_1820, 4);
    ins(32'h00C, 32'h0041_302A, 4);
    ins(32'h010, 32'hAC03_0080, 4); st(32'h80, 32'd2);
    ins(32'h014, 32'hAC06_0084, 4); st(32'h84, 32'd1);
    ins(32'h018, 32'h0022_3822, 4);
    ins(32'h01C, 32'h0001_4100, 4);
    ins(32'h020, 32'h0002_4F02, 4);
    ins(32'h024, 32'h0041_5024, 4);
    ins(32'h028, 32'h0027_5825, 4);
    ins(32'h02C, 32'hAC07_0088, 4); st(32'h88, 32'd8);
    ins(32'h030, 32'hAC08_008C, 4); st(32'h8C, 32'h50);
    ins(32'h034, 32'hAC09_0090, 4); st(32'h90, 32'hF);
    ins(32'h038, 32'hAC0A_0094, 4); st(32'h94, 32'd5);
    ins(32'h03C, 32'hAC0B_0098, 4); st(32'h98, 32'd13);
    ins(32'h040, 32'h2000_0007, 4);
    ins(32'h044, 32'hAC00_009C, 4); st(32'h9C, 32'd0);
    ins(32'h048, 32'h1421_0004, 3);
    ins(32'h04C, 32'h1022_0001, 3);
    ins(32'h050, 32'h1422_0001, 3);
    mem[32'h54 >> 2] = 32'hFC00_0000;
    ins(32'h058, 32'h0800_0040, 3);
    ins(32'h100, 32'h2005_0200, 4);
    ins(32'h104, 32'h00A0_0008, 3);
    ins(32'h200, 32'h8C04_0080, 5); ld(32'h80);
    ins(32'h204, 32'hAC04_00A0, 4); st(32'hA0, 32'd2);
    ins(32'h208, 32'h1000_0001, 3);
    mem[32'h20C >> 2] = 32'hFC00_0000;
    ins(32'h210, 32'hFC00_0000, 0);
    release_reset();
    drain("alu", 1000);
    check_halt("alu", 32'h210);

    // sw then lw through two wait states per access
    start_phase(2, 1);
    mem[2] = 32'hDEAD_BEEF;
    ins(32'h00, 32'h0800_0010, 5);
    ins(32'h40, 32'h2003_0002, 6);
    ins(32'h44, 32'hAC03_0008, 8); st(32'h08, 32'd2);
    ins(32'h48, 32'h8C04_0008, 9); ld(32'h08);
    ins(32'h4C, 32'hAC04_000C, 8); st(32'h0C, 32'd2);
    ins(32'h50, 32'hFC00_0000, 0);
    release_reset();
    drain("wait2", 500);
    check_halt("wait2", 32'h50);

    // jump chain into a self-looping beq, one wait state
    start_phase(1, 0);
    ins(32'h000, 32'h0800_0008, 4);
    ins(32'h020, 32'h0800_0040, 4);
    ins(32'h100, 32'h0800_0004, 4);
    ins(32'h010, 32'h1021_FFFF, 4);
    refetch(32'h010, 4);
    refetch(32'h010, 0);
    release_reset();
    drain("beq_loop", 300);
    check("beq_loop_pc", pc_out & 32'hFFFF_FFF0, 32'h10);

    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
